// File: rtl/fifo_skid_writer.sv
// Write-side skid adapter: upstream valid/ready stream to FIFO push/full, s_ready straight from a flop.
// Optional push counter enabled by defining FIFO_WRITER_COUNT_EN.
module fifo_skid_writer #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    output logic                   fifo_push,
    output logic [DATA_WIDTH-1:0]  fifo_data,
    input  logic                   fifo_full
`ifdef FIFO_WRITER_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] push_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  s_ready_q, s_ready_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;

    logic in_c;
    logic out_c;

    assign in_c      = s_valid & s_ready_q;
    assign out_c     = (state_q != ST_EMPTY) & ~fifo_full;
    assign s_ready   = s_ready_q;
    assign fifo_push = out_c;
    assign fifo_data = main_q;

    // Next-state: the skid slot fills only when a word arrives while main cannot drain.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_c) begin
                    state_d = ST_BUSY;
                    main_d  = s_data;
                end
            end
            ST_BUSY: begin
                if (in_c && out_c) begin
                    main_d = s_data;
                end else if (in_c) begin
                    state_d = ST_FULL;
                    skid_d  = s_data;
                end else if (out_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_c) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        s_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_EMPTY;
            s_ready_q <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
        end
    end

`ifdef FIFO_WRITER_COUNT_EN
    logic [COUNT_WIDTH-1:0] push_count_q;

    // Free-running push counter, wraps naturally at 2^COUNT_WIDTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            push_count_q <= '0;
        end else if (out_c) begin
            push_count_q <= push_count_q + COUNT_WIDTH'(1);
        end
    end

    assign push_count = push_count_q;
`else
    logic [COUNT_WIDTH-1:0] unused_count;
    assign unused_count = '0;
`endif

endmodule

// File: tb/tb_fifo_skid_writer.sv
// Randomised and directed bench for fifo_skid_writer against an occupancy/queue reference model.
// Exercises the push counter when FIFO_WRITER_COUNT_EN is defined.
module tb_fifo_skid_writer;

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          fifo_push;
    logic [DW-1:0] fifo_data;
    logic          fifo_full;
`ifdef FIFO_WRITER_COUNT_EN
    logic [CW-1:0] push_count;
`endif

    fifo_skid_writer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .fifo_push (fifo_push),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full)
`ifdef FIFO_WRITER_COUNT_EN
        ,
        .push_count(push_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    logic [DW-1:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, compare against the model, then advance the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic f);
        bit exp_rdy;
        bit exp_push;
        @(negedge clk);
        s_valid   = v;
        s_data    = d;
        fifo_full = f;
        #1;
        exp_rdy  = (q.size() < 2);
        exp_push = (q.size() > 0) && !f;
        chk("s_ready", 32'(s_ready), 32'(exp_rdy));
        chk("fifo_push", 32'(fifo_push), 32'(exp_push));
        chk("push_while_full", 32'(fifo_push & fifo_full), 32'd0);
        if (exp_push) begin
            chk("fifo_data", 32'(fifo_data), 32'(q[0]));
            void'(q.pop_front());
            pushed++;
        end
        if (v && exp_rdy) q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        s_valid   = 1'b0;
        fifo_full = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_fifo_push", 32'(fifo_push), 32'd0);
        chk("rst_fifo_data", 32'(fifo_data), 32'd0);
`ifdef FIFO_WRITER_COUNT_EN
        chk("rst_push_count", 32'(push_count), 32'd0);
`endif
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_s_ready_low", 32'(s_ready), 32'd0);
        chk("rel_no_push", 32'(fifo_push), 32'd0);
    endtask

    initial begin
        int base;
        reset_n   = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        fifo_full = 1'b0;
        do_reset();
        step(1'b0, '0, 1'b0);

        // T1: reset with two words held discards them.
        step(1'b1, 4'h1, 1'b1);
        step(1'b1, 4'h2, 1'b1);
        step(1'b0, '0, 1'b1);
        do_reset();
        repeat (3) step(1'b0, '0, 1'b0);

        // T2: back-to-back streaming.
        for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        chk("t2_pushed", 32'(pushed), 32'd16);

        // T3: backpressure lands the second word in the skid slot.
        step(1'b1, 4'hA, 1'b0);
        step(1'b1, 4'hB, 1'b1);
        repeat (4) step(1'b1, 4'hC, 1'b1);
        repeat (2) step(1'b1, 4'hC, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        chk("t3_drained", 32'(q.size()), 32'd0);

        // T4: random bubbles on both sides.
        base = pushed;
        for (int c = 0; c < 20000 && (pushed - base) < 1000; c++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 15)),
                 1'($urandom_range(0, 9) < 3));
        end
        chk("t4_words_done", 32'((pushed - base) >= 1000), 32'd1);
        repeat (4) step(1'b0, '0, 1'b0);
        chk("t4_drained", 32'(q.size()), 32'd0);

`ifdef FIFO_WRITER_COUNT_EN
        // T5: counter wraps modulo 2^CW.
        do_reset();
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b1, DW'(i), 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        chk("t5_push_count", 32'(push_count), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
